// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a little-endian byte-lane data RAM.
// Drives registered RAM enables/lanes, waits READ_LATENCY cycles on loads, and extends the result.
module mem_access_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        misalign,
    output logic [31:0] bad_addr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [3:0]  mem_write_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LastCnt = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [4:0]  r_rd;

    logic        w_misalign;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rdata;

    always_comb begin
        w_misalign = 1'b0;
        w_sel      = 4'b1111;
        w_wdata    = req_wdata;
        unique case (req_size)
            2'b00: begin
                w_sel   = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign = req_addr[0];
                w_sel      = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{req_wdata[15:0]}};
            end
            2'b10: w_misalign = (req_addr[1:0] != 2'b00);
            2'b11: w_misalign = 1'b1;
        endcase
    end

    // Lane select uses the latched low address bits, not the live request.
    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_rdata = mem_rdata;
        case (r_size)
            2'b00:   w_rdata = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_rdata = {{16{r_signed & w_half[15]}}, w_half};
            default: w_rdata = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_lane        <= '0;
            r_size        <= '0;
            r_signed      <= 1'b0;
            r_rd          <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            misalign      <= 1'b0;
            bad_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_write_sel <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            misalign   <= 1'b0;
            resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        r_lane   <= req_addr[1:0];
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_rd     <= req_rd;
                        mem_addr <= {req_addr[31:2], 2'b00};
                        if (w_misalign) begin
                            misalign <= 1'b1;
                            bad_addr <= req_addr;
                        end else if (req_we) begin
                            r_state       <= WRITE;
                            req_ready     <= 1'b0;
                            mem_write_en  <= 1'b1;
                            mem_write_sel <= w_sel;
                            mem_wdata     <= w_wdata;
                        end else begin
                            r_state       <= READ;
                            req_ready     <= 1'b0;
                            mem_read_en   <= 1'b1;
                            mem_write_sel <= '0;
                            r_cnt         <= '0;
                        end
                    end
                end
                WRITE: begin
                    mem_write_en  <= 1'b0;
                    mem_write_sel <= '0;
                    resp_valid    <= 1'b1;
                    resp_rdata    <= '0;
                    resp_rd       <= r_rd;
                    r_state       <= RESP;
                end
                READ: begin
                    if (r_cnt == LastCnt) begin
                        mem_read_en <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= w_rdata;
                        resp_rd     <= r_rd;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: two instances (READ_LATENCY 1 and 3) share request inputs.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] mem_rdata = '0;

    logic        rdy1, rv1, mis1, ren1, wen1;
    logic [31:0] rdata1, bad1, maddr1, wdat1;
    logic [4:0]  rrd1;
    logic [3:0]  sel1;
    logic        rdy3, rv3, mis3, ren3, wen3;
    logic [31:0] rdata3, bad3, maddr3, wdat3;
    logic [4:0]  rrd3;
    logic [3:0]  sel3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(rv1), .resp_rdata(rdata1),
        .resp_rd(rrd1), .misalign(mis1), .bad_addr(bad1), .mem_read_en(ren1),
        .mem_write_en(wen1), .mem_write_sel(sel1), .mem_addr(maddr1), .mem_wdata(wdat1),
        .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(rv3), .resp_rdata(rdata3),
        .resp_rd(rrd3), .misalign(mis3), .bad_addr(bad3), .mem_read_en(ren3),
        .mem_write_en(wen3), .mem_write_sel(sel3), .mem_addr(maddr3), .mem_wdata(wdat3),
        .mem_rdata(mem_rdata)
    );

    task automatic wait_idle();
        for (int i = 0; i < 40 && !(rdy1 && rdy3); i++) @(negedge clk);
        total++;
        if (!(rdy1 && rdy3)) begin
            bad++;
            $display("FAIL wait_idle: ready1=%b ready3=%b, required 1 1", rdy1, rdy3);
        end
    endtask

    // Called at a negedge; returns just after the handshake edge.
    task automatic handshake(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({rdy1, rv1, rdata1, rrd1, mis1, bad1, ren1, wen1, sel1, maddr1, wdat1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs1: ready=%b rv=%b ren=%b wen=%b sel=%h addr=%h, required all 0",
                     rdy1, rv1, ren1, wen1, sel1, maddr1);
        end
        total++;
        if ({rdy3, rv3, mis3, ren3, wen3, sel3, bad3} !== '0) begin
            bad++;
            $display("FAIL reset_outputs3: ready=%b rv=%b ren=%b wen=%b, required all 0",
                     rdy3, rv3, ren3, wen3);
        end
        rst = 1'b0;
        #1;
        total++;
        if (rdy1 !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b required 0", rdy1);
        end
        @(negedge clk);
        total++;
        if ({rdy1, rdy3} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_release: got %b%b required 11", rdy1, rdy3);
        end
    endtask

    task automatic test_store(input string name, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [3:0] exp_sel, input logic [31:0] exp_wd);
        exp_t e;
        wait_idle();
        q1.push_back('{rd: rd, data: 32'h0});
        handshake(1'b1, size, 1'b0, addr, wdata, rd);
        @(negedge clk);
        total++;
        if ({wen1, ren1, rv1, rdy1} !== 4'b1000 || sel1 !== exp_sel) begin
            bad++;
            $display("FAIL %s_c1: wen=%b ren=%b rv=%b rdy=%b sel=%b, required 1 0 0 0 sel=%b",
                     name, wen1, ren1, rv1, rdy1, sel1, exp_sel);
        end
        total++;
        if (maddr1 !== (addr & 32'hFFFF_FFFC) || wdat1 !== exp_wd) begin
            bad++;
            $display("FAIL %s_bus: addr=%h wdata=%h, required addr=%h wdata=%h",
                     name, maddr1, wdat1, addr & 32'hFFFF_FFFC, exp_wd);
        end
        @(negedge clk);
        total++;
        if ({wen1, ren1, rv1} !== 3'b001) begin
            bad++;
            $display("FAIL %s_c2: wen=%b ren=%b rv=%b, required 0 0 1", name, wen1, ren1, rv1);
        end
        if (rv1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL %s_resp: unexpected response, required none", name);
            end else begin
                e = q1.pop_front();
                if (rdata1 !== e.data || rrd1 !== e.rd) begin
                    bad++;
                    $display("FAIL %s_resp: rdata=%h rd=%0d, required rdata=%h rd=%0d",
                             name, rdata1, rrd1, e.data, e.rd);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({rdy1, rv1} !== 2'b10) begin
            bad++;
            $display("FAIL %s_c3: ready=%b rv=%b, required 1 0", name, rdy1, rv1);
        end
    endtask

    task automatic test_load1(input string name, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [4:0] rd,
                              input logic [31:0] exp_data);
        exp_t e;
        mem_rdata = 32'h80FF_7F01;
        wait_idle();
        q1.push_back('{rd: rd, data: exp_data});
        handshake(1'b0, size, sgn, addr, 32'h0, rd);
        @(negedge clk);
        total++;
        if ({ren1, wen1, rv1} !== 3'b100 || sel1 !== 4'b0000) begin
            bad++;
            $display("FAIL %s_c1: ren=%b wen=%b rv=%b sel=%b, required 1 0 0 sel=0000",
                     name, ren1, wen1, rv1, sel1);
        end
        @(negedge clk);
        total++;
        if (rv1 !== 1'b1 || ren1 !== 1'b0 || q1.size() == 0) begin
            bad++;
            $display("FAIL %s_c2: rv=%b ren=%b queued=%0d, required rv=1 ren=0 queued>0",
                     name, rv1, ren1, q1.size());
        end else begin
            e = q1.pop_front();
            total++;
            if (rdata1 !== e.data || rrd1 !== e.rd) begin
                bad++;
                $display("FAIL %s_resp: rdata=%h rd=%0d, required rdata=%h rd=%0d",
                         name, rdata1, rrd1, e.data, e.rd);
            end
        end
    endtask

    task automatic test_latency3();
        exp_t e;
        mem_rdata = 32'h1122_3344;
        wait_idle();
        q3.push_back('{rd: 5'd9, data: 32'h1122_3344});
        handshake(1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0, 5'd9);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if ({ren3, wen3, rv3} !== 3'b100) begin
                bad++;
                $display("FAIL lat3_c%0d: ren=%b wen=%b rv=%b, required 1 0 0", c, ren3, wen3, rv3);
            end
        end
        @(posedge clk);
        #1 mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if (rv3 !== 1'b1 || ren3 !== 1'b0 || q3.size() == 0) begin
            bad++;
            $display("FAIL lat3_c4: rv=%b ren=%b queued=%0d, required rv=1 ren=0 queued>0",
                     rv3, ren3, q3.size());
        end else begin
            e = q3.pop_front();
            total++;
            if (rdata3 !== e.data || rrd3 !== e.rd) begin
                bad++;
                $display("FAIL lat3_resp: rdata=%h rd=%0d, required rdata=%h rd=%0d",
                         rdata3, rrd3, e.data, e.rd);
            end
        end
    endtask

    task automatic test_misalign();
        wait_idle();
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_0006; req_wdata = '0; req_rd = 5'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_size = 2'b01; req_addr = 32'h0000_0001; req_wdata = 32'h5555;
        @(negedge clk);
        total++;
        if ({mis1, mis3, rdy1, rdy3} !== 4'b1111 || bad1 !== 32'h6 || bad3 !== 32'h6) begin
            bad++;
            $display("FAIL misalign_first: mis=%b%b rdy=%b%b bad=%h/%h, required 1111 bad=6",
                     mis1, mis3, rdy1, rdy3, bad1, bad3);
        end
        total++;
        if ({ren1, wen1, rv1, ren3, wen3, rv3} !== 6'b0) begin
            bad++;
            $display("FAIL misalign_first_en: %b required 000000", {ren1, wen1, rv1, ren3, wen3, rv3});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({mis1, mis3, rdy1, rdy3} !== 4'b1111 || bad1 !== 32'h1 || bad3 !== 32'h1) begin
            bad++;
            $display("FAIL misalign_second: mis=%b%b rdy=%b%b bad=%h/%h, required 1111 bad=1",
                     mis1, mis3, rdy1, rdy3, bad1, bad3);
        end
        total++;
        if ({ren1, wen1, rv1, ren3, wen3, rv3} !== 6'b0) begin
            bad++;
            $display("FAIL misalign_second_en: %b required 000000", {ren1, wen1, rv1, ren3, wen3, rv3});
        end
        @(negedge clk);
        total++;
        if ({mis1, mis3, rdy1} !== 3'b001 || bad1 !== 32'h1) begin
            bad++;
            $display("FAIL misalign_after: mis=%b%b rdy=%b bad=%h, required 00 1 bad=1",
                     mis1, mis3, rdy1, bad1);
        end
    endtask

    task automatic test_reset_midread();
        wait_idle();
        handshake(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 5'd3);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ren3 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_before: ren=%b required 1", ren3);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({ren3, rdy3, rv3, mis3} !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_async: ren=%b rdy=%b rv=%b mis=%b, required 0000",
                     ren3, rdy3, rv3, mis3);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({rv3, ren3, rdy3} !== 3'b000) begin
                bad++;
                $display("FAIL rstmid_hold%0d: rv=%b ren=%b rdy=%b, required 000", c, rv3, ren3, rdy3);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy3, rv3, ren3} !== 3'b100) begin
            bad++;
            $display("FAIL rstmid_release: rdy=%b rv=%b ren=%b, required 1 0 0", rdy3, rv3, ren3);
        end
        @(negedge clk);
        total++;
        if ({rv3, ren3} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_noresp: rv=%b ren=%b, required 00", rv3, ren3);
        end
    endtask

    initial begin
        test_reset();
        test_store("sw", 2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 5'd4, 4'b1111, 32'hDEAD_BEEF);
        test_store("sb", 2'b00, 32'h0000_0006, 32'h0000_00A5, 5'd5, 4'b0100, 32'hA5A5_A5A5);
        test_store("sh", 2'b01, 32'h0000_0002, 32'h0000_1234, 5'd6, 4'b1100, 32'h1234_1234);
        test_load1("lb", 2'b00, 1'b1, 32'h0000_0002, 5'd17, 32'hFFFF_FFFF);
        test_load1("lbu", 2'b00, 1'b0, 32'h0000_0003, 5'd18, 32'h0000_0080);
        test_load1("lh", 2'b01, 1'b1, 32'h0000_0002, 5'd19, 32'hFFFF_80FF);
        test_load1("lhu", 2'b01, 1'b0, 32'h0000_0000, 5'd20, 32'h0000_7F01);
        test_load1("lw", 2'b10, 1'b1, 32'h0000_0004, 5'd21, 32'h80FF_7F01);
        test_latency3();
        test_misalign();
        test_reset_midread();
        total++;
        if (q1.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d/%0d, required 0/0", q1.size(), q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the byte-lane data RAM: accepts one load/store request at a time from the pipeline and drives the RAM port (read/write enables, 4-bit byte-write select, word-aligned address, write data).
- For loads, waits a configurable number of cycles, then extracts the addressed byte/halfword/word and sign- or zero-extends it.
- Flags misaligned accesses without touching memory.
- Byte order is little-endian: lane k = bits [8k+7:8k].

Parameters:
READ_LATENCY, 1, cycles mem_read_en is held before mem_rdata is sampled (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle and accepting a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_rd  in  5  destination register tag, returned with the response
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  extended load data; 0 for stores
resp_rd  out  5  tag of the completed request
misalign  out  1  one-cycle pulse: request rejected
bad_addr  out  32  address of the last rejected request
mem_read_en  out  1  RAM read enable
mem_write_en  out  1  RAM write enable
mem_write_sel  out  4  RAM byte-lane write select
mem_addr  out  32  RAM address, {req_addr[31:2],2'b00}
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data

Behaviour:
- All outputs are registered.
- Reset value of every output is 0.
  - req_ready rises at the first clock edge after rst deasserts.
  - rst asserted mid-access clears state and outputs at once; no resp_valid and no misalign are issued for the aborted request.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1. A handshake occurs at an edge with req_valid && req_ready. On that edge:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11): stay in IDLE, misalign=1 for the next cycle, bad_addr<=req_addr, no mem enable asserted, req_ready stays 1.
  - Aligned store: go to WRITE, req_ready<=0.
  - Aligned load: go to READ, req_ready<=0, cnt<=0.
  - Request fields (addr, size, signed, wdata, rd) are latched.
- WRITE (exactly 1 cycle): mem_write_en=1.
  - mem_write_sel: byte -> 1<<addr[1:0]; half -> 0011 if addr[1]=0, else 1100; word -> 1111.
  - mem_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - Next state is RESP.
- READ: mem_read_en=1 and mem_write_sel=0 for exactly READ_LATENCY cycles; cnt increments each cycle.
  - On the edge ending the last READ cycle: capture mem_rdata and select the lane.
    - byte: mem_rdata[8*a+7:8*a], a = addr[1:0].
    - half: addr[1] ? [31:16] : [15:0].
    - word: all 32 bits.
  - Extend to 32 bits using req_signed (sign-extend if 1, zero-extend if 0); word loads ignore req_signed.
  - Next state is RESP.
- RESP (1 cycle): resp_valid=1; resp_rdata = extended data (0 for a store); resp_rd = latched tag; all mem enables 0.
  - Next state is IDLE with req_ready<=1, so a new request can be accepted on the following edge.
- Latency from handshake edge:
  - store: mem_write_en in cycle 1, resp_valid in cycle 2.
  - load: mem_read_en in cycles 1..L, resp_valid in cycle L+1, with L = READ_LATENCY.
- mem_addr holds the latched aligned address from the handshake until the next handshake.
- mem_read_en and mem_write_en are never asserted together.
- resp_valid and misalign are never asserted together.
- Back-to-back misaligned requests each produce their own misalign pulse; bad_addr tracks the latest one.
- Request inputs are ignored while req_ready=0.

Test Plan:
- Reset release, then sw addr 0x0000_0008 wdata 0xDEAD_BEEF: mem_write_en=1 for 1 cycle with sel=1111, mem_addr=0x8, mem_wdata=0xDEADBEEF; resp_valid at cycle 2 with rdata 0.
- sb addr 0x0000_0006 wdata 0x0000_00A5: sel=0100, mem_wdata=0xA5A5A5A5. sh addr 0x2 wdata 0x1234: sel=1100, mem_wdata=0x12341234.
- L=1, mem_rdata=0x80FF_7F01:
  - lb signed addr 0x2: resp_rdata=0xFFFFFFFF.
  - lbu addr 0x3: 0x00000080.
  - lh signed addr 0x2: 0xFFFF80FF.
  - lhu addr 0x0: 0x00007F01.
  - lw: 0x80FF7F01.
  - resp_rd echoes the request tag (e.g. 5'd17).
- READ_LATENCY=3, lw: mem_read_en high for exactly 3 cycles; resp_valid in cycle 4; mem_rdata changed after the sample edge does not affect resp_rdata.
- lw addr 0x0000_0006, then sh addr 0x0000_0001, back-to-back: two misalign pulses; bad_addr=0x6, then 0x1; no mem enable ever asserted; req_ready stays 1.
- Assert rst during a READ with READ_LATENCY=3 (cycle 2): mem_read_en drops without waiting for a clock edge; no resp_valid; req_ready=1 one edge after rst release.
